// File: rtl/ternary_sampler.sv
// ternary_sampler: turns random coin bytes into a stream of N ternary coefficients (byte mod 3, last one forced to 0)
module ternary_sampler #(
   parameter int N      = 701,
   parameter int COIN_W = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   coin_req,
   input  logic                   coin_valid,
   input  logic [COIN_W-1:0]      coin_data,
   output logic                   coef_valid,
   input  logic                   coef_ready,
   output logic [1:0]             coef_data,
   output logic [$clog2(N)-1:0]   coef_index,
   output logic                   busy,
   output logic                   done
);
   localparam int NB = COIN_W / 8;
   localparam int IW = $clog2(N);
   localparam int PW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 2);
   localparam logic [PW-1:0] LAST_PTR = PW'(NB - 1);

   typedef enum logic [2:0] {IDLE, FETCH, EMIT, ZERO, DONE} state_t;
   state_t state, nxt;

   logic [COIN_W-1:0] coin_buf;
   logic [PW-1:0]     ptr;
   logic [IW-1:0]     idx;
   logic [7:0]        rem;
   logic              xfer;

   // the buffer shifts right on every consumed byte, so the current byte is always the low one
   assign rem = coin_buf[7:0] % 8'd3;

   always_comb begin
      nxt        = state;
      coin_req   = state == FETCH;
      coef_valid = state == EMIT || state == ZERO;
      coef_data  = state == EMIT ? rem[1:0] : 2'b00;
      coef_index = idx;
      busy       = state != IDLE;
      done       = state == DONE;
      xfer       = coef_valid && coef_ready;
      case (state)
         IDLE:  nxt = start ? FETCH : IDLE;
         FETCH: nxt = coin_valid ? EMIT : FETCH;
         EMIT:  nxt = !xfer ? EMIT : idx == LAST_IDX ? ZERO : ptr == LAST_PTR ? FETCH : EMIT;
         ZERO:  nxt = xfer ? DONE : ZERO;
         DONE:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         coin_buf <= '0;
         ptr      <= '0;
         idx      <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && start) idx <= '0;
         if (state == FETCH && coin_valid) begin
            coin_buf <= coin_data;
            ptr      <= '0;
         end
         if (state == EMIT && coef_ready) begin
            coin_buf <= coin_buf >> 8;
            ptr      <= ptr + 1'b1;
            idx      <= idx + 1'b1;
         end
      end
   end
endmodule
